// File: rtl/vend_stock_arbiter.sv
// vend_stock_arbiter: owns the water/soda/lemon stock counters and arbitrates
// between the customer vend port and the service restock port. Each port uses
// a 4-phase req/ack handshake, and ties are resolved round-robin.
// Optional feature macro: VEND_LOW_STOCK_ALERT_EN adds a registered low_stock[2:0] output.
module vend_stock_arbiter #(
  parameter int unsigned MAX_STOCK  = 31,
  parameter int unsigned INIT_STOCK = 0,
  parameter int unsigned LOW_THRESH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend_req,
  input  logic [1:0] vend_sel,
  output logic       vend_ack,
  output logic       vend_ok,
  input  logic       rs_req,
  input  logic [1:0] rs_sel,
  input  logic [4:0] rs_qty,
  output logic       rs_ack,
  output logic       rs_ovf,
  output logic [4:0] Waterbottle_available,
  output logic [4:0] Sodabottle_available,
`ifdef VEND_LOW_STOCK_ALERT_EN
  output logic [4:0] Lemonwater_available,
  output logic [2:0] low_stock
`else
  output logic [4:0] Lemonwater_available
`endif
);

  localparam int unsigned CW = 5;
  localparam int unsigned SW = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_VEND = 2'd1,
    ACK_RS   = 2'd2
  } state_t;

  state_t          state_q;
  logic            rr_last_q;  // 1: vend was served last, 0: restock was served last
  logic            vend_ack_q, vend_ok_q, rs_ack_q, rs_ovf_q;
  logic [CW-1:0]   water_q, soda_q, lemon_q;
  logic [CW-1:0]   water_d, soda_d, lemon_d;

  logic            grant_vend_c, grant_rs_c;
  logic [CW-1:0]   vend_cnt_c, rs_cnt_c, rs_new_c;
  logic [SW-1:0]   rs_sum_c;
  logic            vend_hit_c, rs_clip_c, rs_ovf_c;

  function automatic logic [CW-1:0] pick(input logic [1:0] sel, input logic [CW-1:0] w,
                                         input logic [CW-1:0] s, input logic [CW-1:0] l);
    case (sel)
      2'b01:   pick = w;
      2'b10:   pick = s;
      2'b11:   pick = l;
      default: pick = '0;
    endcase
  endfunction

  // Round-robin grant and per-port update arithmetic.
  always_comb begin
    grant_vend_c = (state_q == IDLE) && vend_req && (!rs_req || !rr_last_q);
    grant_rs_c   = (state_q == IDLE) && rs_req && !grant_vend_c;
    vend_cnt_c   = pick(vend_sel, water_q, soda_q, lemon_q);
    rs_cnt_c     = pick(rs_sel, water_q, soda_q, lemon_q);
    vend_hit_c   = (vend_sel != 2'b00) && (vend_cnt_c != '0);
    rs_sum_c     = SW'(rs_cnt_c) + SW'(rs_qty);
    rs_clip_c    = rs_sum_c > SW'(MAX_STOCK);
    rs_new_c     = rs_clip_c ? CW'(MAX_STOCK) : rs_sum_c[CW-1:0];
    rs_ovf_c     = (rs_sel == 2'b00) || rs_clip_c;
  end

  // Next counter values: only the granted port's selected counter moves.
  always_comb begin
    water_d = water_q;
    soda_d  = soda_q;
    lemon_d = lemon_q;
    if (grant_vend_c && vend_hit_c) begin
      case (vend_sel)
        2'b01:   water_d = water_q - CW'(1);
        2'b10:   soda_d  = soda_q - CW'(1);
        2'b11:   lemon_d = lemon_q - CW'(1);
        default: ;
      endcase
    end else if (grant_rs_c) begin
      case (rs_sel)
        2'b01:   water_d = rs_new_c;
        2'b10:   soda_d  = rs_new_c;
        2'b11:   lemon_d = rs_new_c;
        default: ;
      endcase
    end
  end

  // Handshake FSM, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b0;
      vend_ack_q <= 1'b0;
      vend_ok_q  <= 1'b0;
      rs_ack_q   <= 1'b0;
      rs_ovf_q   <= 1'b0;
      water_q    <= CW'(INIT_STOCK);
      soda_q     <= CW'(INIT_STOCK);
      lemon_q    <= CW'(INIT_STOCK);
    end else begin
      water_q <= water_d;
      soda_q  <= soda_d;
      lemon_q <= lemon_d;
      case (state_q)
        IDLE: begin
          if (grant_vend_c) begin
            vend_ack_q <= 1'b1;
            vend_ok_q  <= vend_hit_c;
            rr_last_q  <= 1'b1;
            state_q    <= ACK_VEND;
          end else if (grant_rs_c) begin
            rs_ack_q  <= 1'b1;
            rs_ovf_q  <= rs_ovf_c;
            rr_last_q <= 1'b0;
            state_q   <= ACK_RS;
          end
        end
        ACK_VEND: begin
          if (!vend_req) begin
            vend_ack_q <= 1'b0;
            vend_ok_q  <= 1'b0;
            state_q    <= IDLE;
          end
        end
        ACK_RS: begin
          if (!rs_req) begin
            rs_ack_q <= 1'b0;
            rs_ovf_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          vend_ack_q <= 1'b0;
          vend_ok_q  <= 1'b0;
          rs_ack_q   <= 1'b0;
          rs_ovf_q   <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign vend_ack              = vend_ack_q;
  assign vend_ok               = vend_ok_q;
  assign rs_ack                = rs_ack_q;
  assign rs_ovf                = rs_ovf_q;
  assign Waterbottle_available = water_q;
  assign Sodabottle_available  = soda_q;
  assign Lemonwater_available  = lemon_q;

`ifdef VEND_LOW_STOCK_ALERT_EN
  localparam logic InitLow = (INIT_STOCK <= LOW_THRESH);
  logic [2:0] low_stock_q;

  // Low-stock flags track the counters on the same edge they change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_stock_q <= {3{InitLow}};
    end else begin
      low_stock_q <= {lemon_d <= CW'(LOW_THRESH), soda_d <= CW'(LOW_THRESH),
                      water_d <= CW'(LOW_THRESH)};
    end
  end

  assign low_stock = low_stock_q;
`else
  logic unused_low_thresh;
  assign unused_low_thresh = ^CW'(LOW_THRESH);
`endif

endmodule

// File: tb/tb_vend_stock_arbiter.sv
// Scoreboard bench for vend_stock_arbiter: the driver pushes the expected outcome
// of each handshake from a behavioural stock model, and a monitor pops and
// checks it whenever an ack rises.
module tb_vend_stock_arbiter;

  localparam int unsigned MAX  = 31;
  localparam int unsigned INIT = 0;
  localparam int unsigned LOW  = 2;

  logic       clk, reset;
  logic       vend_req, vend_ack, vend_ok;
  logic [1:0] vend_sel;
  logic       rs_req, rs_ack, rs_ovf;
  logic [1:0] rs_sel;
  logic [4:0] rs_qty;
  logic [4:0] water, soda, lemon;
`ifdef VEND_LOW_STOCK_ALERT_EN
  logic [2:0] low_stock;
`endif

  vend_stock_arbiter #(.MAX_STOCK(MAX), .INIT_STOCK(INIT), .LOW_THRESH(LOW)) dut (
    .clk(clk), .reset(reset),
    .vend_req(vend_req), .vend_sel(vend_sel), .vend_ack(vend_ack), .vend_ok(vend_ok),
    .rs_req(rs_req), .rs_sel(rs_sel), .rs_qty(rs_qty), .rs_ack(rs_ack), .rs_ovf(rs_ovf),
    .Waterbottle_available(water), .Sodabottle_available(soda),
`ifdef VEND_LOW_STOCK_ALERT_EN
    .Lemonwater_available(lemon), .low_stock(low_stock)
`else
    .Lemonwater_available(lemon)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit port;  // 0 vend, 1 restock
    bit flag;  // vend_ok or rs_ovf
    int w, s, l;
  } exp_t;

  exp_t q[$];
  int   stock[4];
  bit   last_vend;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  function automatic int low_mask();
    return ((stock[3] <= int'(LOW)) ? 4 : 0) + ((stock[2] <= int'(LOW)) ? 2 : 0) +
           ((stock[1] <= int'(LOW)) ? 1 : 0);
  endfunction

  task automatic push_entry(input bit port, input bit flag);
    exp_t e;
    e.port = port;
    e.flag = flag;
    e.w = stock[1];
    e.s = stock[2];
    e.l = stock[3];
    q.push_back(e);
  endtask

  // A sale takes one bottle if the product is valid and in stock.
  task automatic model_vend(input int sel);
    bit ok;
    ok = (sel != 0) && (stock[sel] > 0);
    if (ok) stock[sel] = stock[sel] - 1;
    last_vend = 1'b1;
    push_entry(1'b0, ok);
  endtask

  // A restock adds bottles, clipping at the ceiling; product 0 is flagged.
  task automatic model_rs(input int sel, input int qty);
    bit ovf;
    if (sel == 0) ovf = 1'b1;
    else if (stock[sel] + qty > int'(MAX)) begin
      stock[sel] = int'(MAX);
      ovf = 1'b1;
    end else begin
      stock[sel] = stock[sel] + qty;
      ovf = 1'b0;
    end
    last_vend = 1'b0;
    push_entry(1'b1, ovf);
  endtask

  task automatic model_reset();
    for (int i = 1; i < 4; i++) stock[i] = int'(INIT);
    last_vend = 1'b0;
    q.delete();
  endtask

  task automatic pop_check(input bit port);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_ack", 1, 0);
    end else begin
      e = q.pop_front();
      chk("ack_port", int'(port), int'(e.port));
      chk(port ? "rs_ovf" : "vend_ok", port ? int'(rs_ovf) : int'(vend_ok), int'(e.flag));
      chk("water_at_ack", int'(water), e.w);
      chk("soda_at_ack", int'(soda), e.s);
      chk("lemon_at_ack", int'(lemon), e.l);
`ifdef VEND_LOW_STOCK_ALERT_EN
      chk("low_stock_at_ack", int'(low_stock),
          ((e.l <= int'(LOW)) ? 4 : 0) + ((e.s <= int'(LOW)) ? 2 : 0) + ((e.w <= int'(LOW)) ? 1 : 0));
`endif
    end
  endtask

  // Monitor: check each ack rise against the scoreboard; when nothing is
  // outstanding the counters must hold the model's values.
  bit pv, pr;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (vend_ack && !pv) pop_check(1'b0);
      if (rs_ack && !pr) pop_check(1'b1);
      if (q.size() == 0) begin
        chk("water_hold", int'(water), stock[1]);
        chk("soda_hold", int'(soda), stock[2]);
        chk("lemon_hold", int'(lemon), stock[3]);
`ifdef VEND_LOW_STOCK_ALERT_EN
        chk("low_stock_hold", int'(low_stock), low_mask());
`endif
      end
      pv = vend_ack;
      pr = rs_ack;
    end
  end

  // Run one handshake (or a simultaneous pair); each requester holds req for
  // one extra cycle after ack while scrambling its payload, then releases.
  task automatic run_txn(input bit dv, input bit dr, input int vs, input int rsl, input int qty);
    bit vheld, rheld, vrel, rrel, done;
    @(negedge clk);
    if (dv && dr) begin
      if (last_vend) begin
        model_rs(rsl, qty);
        model_vend(vs);
      end else begin
        model_vend(vs);
        model_rs(rsl, qty);
      end
    end else if (dv) model_vend(vs);
    else model_rs(rsl, qty);
    vend_sel = 2'(vs);
    rs_sel   = 2'(rsl);
    rs_qty   = 5'(qty);
    vend_req = dv;
    rs_req   = dr;
    vheld = 0; rheld = 0; vrel = 0; rrel = 0; done = 0;
    for (int cyc = 0; cyc < 24 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) chk("grant_latency", int'(vend_ack) + int'(rs_ack), 1);
      if (vrel || rrel) chk("release_gap", int'(vend_ack) + int'(rs_ack), 0);
      vrel = 0;
      rrel = 0;
      if (!vend_req && !rs_req && !vend_ack && !rs_ack) done = 1;
      else begin
        @(negedge clk);
        if (vend_req && vend_ack) begin
          if (vheld) begin vend_req = 1'b0; vrel = 1; end
          else begin vheld = 1; vend_sel = 2'($urandom); end
        end
        if (rs_req && rs_ack) begin
          if (rheld) begin rs_req = 1'b0; rrel = 1; end
          else begin rheld = 1; rs_sel = 2'($urandom); rs_qty = 5'($urandom); end
        end
      end
    end
    if (!done) begin
      chk("handshake_timeout", 0, 1);
      vend_req = 1'b0;
      rs_req   = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    vend_req = 1'b0; vend_sel = 2'b00;
    rs_req = 1'b0; rs_sel = 2'b00; rs_qty = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_vend_ack", int'(vend_ack), 0);
    chk("reset_rs_ack", int'(rs_ack), 0);
    chk("reset_water", int'(water), int'(INIT));
    chk("reset_soda", int'(soda), int'(INIT));
    chk("reset_lemon", int'(lemon), int'(INIT));
    reset = 1'b0;

    // Low-stock edge: water 3 then one sale brings it to the threshold.
    run_txn(0, 1, 0, 1, 3);
    run_txn(1, 0, 1, 0, 0);
    // Restock, saturation and invalid product.
    run_txn(0, 1, 0, 1, 8);
    run_txn(0, 1, 0, 2, 29);
    run_txn(0, 1, 0, 2, 5);
    run_txn(0, 1, 0, 0, 4);
    run_txn(0, 1, 0, 3, 0);
    // Lemon down to empty, then underflow and invalid selection.
    run_txn(0, 1, 0, 3, 1);
    run_txn(1, 0, 3, 0, 0);
    run_txn(1, 0, 3, 0, 0);
    run_txn(1, 0, 0, 0, 0);

    // Reset asserted while vend_ack is high.
    @(negedge clk);
    model_vend(2);
    vend_sel = 2'b10;
    vend_req = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_reset_vend_ack", int'(vend_ack), 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midreset_vend_ack", int'(vend_ack), 0);
    chk("midreset_vend_ok", int'(vend_ok), 0);
    chk("midreset_water", int'(water), int'(INIT));
    chk("midreset_soda", int'(soda), int'(INIT));
    chk("midreset_lemon", int'(lemon), int'(INIT));
    vend_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Two back-to-back ties: vend wins the first, restock the second.
    run_txn(0, 1, 0, 1, 6);
    run_txn(1, 1, 1, 1, 7);
    run_txn(1, 1, 2, 2, 3);

    for (int n = 0; n < 80; n++) begin
      int kind, vs, rsl, qty;
      kind = int'($urandom_range(0, 2));
      vs   = int'($urandom_range(0, 3));
      rsl  = int'($urandom_range(0, 3));
      qty  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 9));
      run_txn(kind != 1, kind != 0, vs, rsl, qty);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
